// File: rtl/ascon_arbiter.sv
// Round-robin owner of one shared ascon_core: one complete operation per grant, NREQ requesters.
// Latency: request->grant 1 cycle, c_mode pulses in the grant's first cycle, r_done 1 cycle after c_done rises.
// Backpressure: handshakes pass combinationally between granted port and core; other ports see ready=0. Optional watchdog: ASCON_ARB_WATCHDOG_EN.
module ascon_arbiter #(
    parameter int NREQ  = 4,
    parameter int WDT_W = 16,
    localparam int CCW  = 32,
    localparam int MW   = 4,
    localparam int TW   = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // requester side
    input  logic [NREQ-1:0][MW-1:0]   r_mode,
    input  logic [NREQ-1:0][CCW-1:0]  r_key,
    input  logic [NREQ-1:0]           r_key_valid,
    output logic [NREQ-1:0]           r_key_ready,
    input  logic [NREQ-1:0][CCW-1:0]  r_bdi,
    input  logic [NREQ-1:0]           r_bdi_valid,
    output logic [NREQ-1:0]           r_bdi_ready,
    input  logic [NREQ-1:0][TW-1:0]   r_bdi_type,
    input  logic [NREQ-1:0]           r_bdi_eot,
    input  logic [NREQ-1:0]           r_bdi_eoi,
    output logic [NREQ-1:0][CCW-1:0]  r_bdo,
    output logic [NREQ-1:0]           r_bdo_valid,
    input  logic [NREQ-1:0]           r_bdo_ready,
    output logic [NREQ-1:0][TW-1:0]   r_bdo_type,
    output logic [NREQ-1:0]           r_bdo_eot,
    output logic [NREQ-1:0]           r_bdo_eoo,
    output logic [NREQ-1:0]           r_grant,
    output logic [NREQ-1:0]           r_done,
    output logic [NREQ-1:0]           r_auth,
    output logic [NREQ-1:0]           r_auth_valid,
    // core side
    output logic [MW-1:0]             c_mode,
    output logic [CCW-1:0]            c_key,
    output logic                      c_key_valid,
    input  logic                      c_key_ready,
    output logic [CCW-1:0]            c_bdi,
    output logic                      c_bdi_valid,
    input  logic                      c_bdi_ready,
    output logic [TW-1:0]             c_bdi_type,
    output logic                      c_bdi_eot,
    output logic                      c_bdi_eoi,
    input  logic [CCW-1:0]            c_bdo,
    input  logic                      c_bdo_valid,
    output logic                      c_bdo_ready,
    input  logic [TW-1:0]             c_bdo_type,
    input  logic                      c_bdo_eot,
    input  logic                      c_bdo_eoo,
    input  logic                      c_done,
    input  logic                      c_auth,
    input  logic                      c_auth_valid,
    output logic                      c_rst,
    output logic                      busy
`ifdef ASCON_ARB_WATCHDOG_EN
    ,
    output logic                      abort_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [MW-1:0] M_NONE = '0;

    // Elaboration-time guard on the supported configuration range.
    if (NREQ < 2 || NREQ > 8 || WDT_W < 2) begin : g_cfg_check
        $error("ascon_arbiter: NREQ must be 2..8 and WDT_W at least 2");
    end

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [MW-1:0]     mode_q, mode_d;
    logic              done_q;
    logic              c_rst_q, c_rst_d;
    logic [NREQ-1:0]   r_done_q, r_done_d;
    logic [NREQ-1:0]   r_auth_q, r_auth_d;
    logic [NREQ-1:0]   r_auth_valid_q, r_auth_valid_d;

    logic              hit;
    logic [IW-1:0]     pick;
    logic [IW:0]       cand;

`ifdef ASCON_ARB_WATCHDOG_EN
    localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};
    logic [WDT_W-1:0]  wdt_q, wdt_d;
    logic              abort_q, abort_d;
    logic              hs;
`endif

    // Round-robin search: first requesting port after the last served one, with wrap.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        cand = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!hit && r_mode[cand[IW-1:0]] != M_NONE) begin
                hit  = 1'b1;
                pick = cand[IW-1:0];
            end
        end
    end

`ifdef ASCON_ARB_WATCHDOG_EN
    // Any routed handshake counts as forward progress for the watchdog.
    always_comb begin
        hs = (c_key_valid & c_key_ready) | (c_bdi_valid & c_bdi_ready) | (c_bdo_valid & c_bdo_ready);
    end
`endif

    // Next-state logic: grant selection, operation sequencing, completion capture.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        gidx_d         = gidx_q;
        ptr_d          = ptr_q;
        mode_d         = mode_q;
        c_rst_d        = 1'b0;
        r_done_d       = '0;
        r_auth_d       = '0;
        r_auth_valid_d = '0;
`ifdef ASCON_ARB_WATCHDOG_EN
        wdt_d          = wdt_q;
        abort_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    gidx_d        = pick;
                    // Latch the mode so the requester may drop r_mode once granted.
                    mode_d        = r_mode[pick];
                    state_d       = S_START;
                end
            end
            S_START: begin
                state_d = S_RUN;
`ifdef ASCON_ARB_WATCHDOG_EN
                wdt_d   = '0;
`endif
            end
            S_RUN: begin
                if (c_done && !done_q) begin
                    state_d        = S_RELEASE;
                    r_done_d       = grant_q;
                    r_auth_d       = c_auth ? grant_q : '0;
                    r_auth_valid_d = c_auth_valid ? grant_q : '0;
                end
`ifdef ASCON_ARB_WATCHDOG_EN
                else if (hs) begin
                    wdt_d = '0;
                end else if (wdt_q == WDT_LAST) begin
                    // Counter is about to saturate: abandon the operation and reset the core.
                    state_d = S_IDLE;
                    r_done_d = grant_q;
                    abort_d = 1'b1;
                    c_rst_d = 1'b1;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    wdt_d   = '0;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = gidx_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; core reset is held until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            gidx_q         <= '0;
            ptr_q          <= IW'(NREQ - 1);
            mode_q         <= M_NONE;
            done_q         <= 1'b0;
            c_rst_q        <= 1'b1;
            r_done_q       <= '0;
            r_auth_q       <= '0;
            r_auth_valid_q <= '0;
`ifdef ASCON_ARB_WATCHDOG_EN
            wdt_q          <= '0;
            abort_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            gidx_q         <= gidx_d;
            ptr_q          <= ptr_d;
            mode_q         <= mode_d;
            done_q         <= c_done;
            c_rst_q        <= c_rst_d;
            r_done_q       <= r_done_d;
            r_auth_q       <= r_auth_d;
            r_auth_valid_q <= r_auth_valid_d;
`ifdef ASCON_ARB_WATCHDOG_EN
            wdt_q          <= wdt_d;
            abort_q        <= abort_d;
`endif
        end
    end

    // Datapath mux: forward direction from START, return stream only in RUN.
    always_comb begin
        c_mode      = M_NONE;
        c_key       = '0;
        c_key_valid = 1'b0;
        c_bdi       = '0;
        c_bdi_valid = 1'b0;
        c_bdi_type  = '0;
        c_bdi_eot   = 1'b0;
        c_bdi_eoi   = 1'b0;
        c_bdo_ready = 1'b0;
        r_key_ready = '0;
        r_bdi_ready = '0;
        r_bdo       = '0;
        r_bdo_valid = '0;
        r_bdo_type  = '0;
        r_bdo_eot   = '0;
        r_bdo_eoo   = '0;
        if (state_q == S_START) begin
            c_mode = mode_q;
        end
        if (state_q == S_START || state_q == S_RUN) begin
            c_key               = r_key[gidx_q];
            c_key_valid         = r_key_valid[gidx_q];
            c_bdi               = r_bdi[gidx_q];
            c_bdi_valid         = r_bdi_valid[gidx_q];
            c_bdi_type          = r_bdi_type[gidx_q];
            c_bdi_eot           = r_bdi_eot[gidx_q];
            c_bdi_eoi           = r_bdi_eoi[gidx_q];
            r_key_ready[gidx_q] = c_key_ready;
            r_bdi_ready[gidx_q] = c_bdi_ready;
        end
        if (state_q == S_RUN) begin
            c_bdo_ready         = r_bdo_ready[gidx_q];
            r_bdo[gidx_q]       = c_bdo;
            r_bdo_valid[gidx_q] = c_bdo_valid;
            r_bdo_type[gidx_q]  = c_bdo_type;
            r_bdo_eot[gidx_q]   = c_bdo_eot;
            r_bdo_eoo[gidx_q]   = c_bdo_eoo;
        end
    end

    assign r_grant      = grant_q;
    assign r_done       = r_done_q;
    assign r_auth       = r_auth_q;
    assign r_auth_valid = r_auth_valid_q;
    assign c_rst        = c_rst_q;
    assign busy         = (state_q != S_IDLE);
`ifdef ASCON_ARB_WATCHDOG_EN
    assign abort_err    = abort_q;
`endif

endmodule
